// File: rtl/vector100_deser.sv
// vector100_deser: serial-to-parallel word assembler with a valid/ready output slot.
// The next word keeps assembling in sr while a finished word waits in out_reg.
module vector100_deser #(
   parameter int WIDTH = 100,
   parameter bit LSB_FIRST = 1'b1,
   parameter int CW = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             areset_n,
   input  logic             in_valid,
   input  logic             in_bit,
   output logic             in_ready,
   input  logic             flush,
   output logic [WIDTH-1:0] dout,
   output logic             dout_valid,
   input  logic             dout_ready,
   output logic [CW-1:0]    bit_count
);
   logic [WIDTH-1:0] sr, sr_nx, out_reg;
   logic [CW-1:0] cnt;
   logic vld, last, acc, done;
   assign last = cnt == CW'(WIDTH - 1);
   // stall only when the next bit would finish a word that has nowhere to go
   assign in_ready = ~(vld & ~dout_ready & last);
   assign acc = in_valid & in_ready & ~flush;
   assign done = acc & last;
   assign sr_nx = LSB_FIRST ? {in_bit, sr[WIDTH-1:1]} : {sr[WIDTH-2:0], in_bit};
   assign dout = out_reg;
   assign dout_valid = vld;
   assign bit_count = cnt;
   always_ff @(posedge clk or negedge areset_n)
      if (!areset_n) begin
         sr <= '0;
         cnt <= '0;
         out_reg <= '0;
         vld <= 1'b0;
      end else begin
         if (flush) begin
            sr <= '0;
            cnt <= '0;
         end else if (acc) begin
            sr <= last ? '0 : sr_nx;
            cnt <= last ? '0 : cnt + 1'b1;
         end
         if (done) begin
            out_reg <= sr_nx;
            vld <= 1'b1;
         end else if (vld & dout_ready)
            vld <= 1'b0;
      end
endmodule

// File: tb/tb_vector100_deser.sv
// tb_vector100_deser: directed scoreboard bench; an LSB-first and an MSB-first instance share stimulus.
module tb_vector100_deser;
   localparam int W = 100;
   logic clk = 1'b0, areset_n = 1'b0;
   logic in_valid = 1'b0, in_bit = 1'b0, flush = 1'b0, dout_ready = 1'b0;
   logic in_ready, in_ready_m, dout_valid, dout_valid_m;
   logic [W-1:0] dout, dout_m;
   logic [6:0] bit_count, bit_count_m;
   int tests = 0, fails = 0, npop = 0, cnt_err = 0, mcnt = 0;
   logic [W-1:0] mword = '0;
   logic [W-1:0] q[$];
   logic [W-1:0] wa = 100'h5555555555555555555555555;
   logic [W-1:0] wb = 100'hAAAAAAAAAAAAAAAAAAAAAAAAA;
   logic [W-1:0] ww = 100'h0123456789ABCDEF012345678;
   logic [W-1:0] one = 100'h1;
   logic [W-1:0] top = {1'b1, 99'h0};

   vector100_deser #(.WIDTH(W), .LSB_FIRST(1'b1)) u_lsb (
      .clk(clk), .areset_n(areset_n), .in_valid(in_valid), .in_bit(in_bit), .in_ready(in_ready),
      .flush(flush), .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready), .bit_count(bit_count));
   vector100_deser #(.WIDTH(W), .LSB_FIRST(1'b0)) u_msb (
      .clk(clk), .areset_n(areset_n), .in_valid(in_valid), .in_bit(in_bit), .in_ready(in_ready_m),
      .flush(flush), .dout(dout_m), .dout_valid(dout_valid_m), .dout_ready(dout_ready), .bit_count(bit_count_m));

   always #5 clk = ~clk;

   function automatic logic [W-1:0] rev(input logic [W-1:0] v);
      for (int i = 0; i < W; i++) rev[i] = v[W-1-i];
   endfunction

   task automatic chk(input string n, input logic [W-1:0] a, input logic [W-1:0] e);
      tests++;
      if (a !== e) begin
         fails++;
         $display("FAIL %s: got %h expected %h", n, a, e);
      end
   endtask

   // one clock: drive at negedge, update the bit-level model, return at the next negedge
   task automatic cyc(input logic v, input logic b, input logic r, input logic f);
      in_valid = v;
      in_bit = b;
      dout_ready = r;
      flush = f;
      #1;
      if (f) begin
         mcnt = 0;
         mword = '0;
      end else if (v && in_ready) begin
         mword[mcnt] = b;
         if (mcnt == W - 1) begin
            q.push_back(mword);
            mcnt = 0;
            mword = '0;
         end else mcnt++;
      end
      @(posedge clk);
      @(negedge clk);
      if (bit_count !== 7'(mcnt) || bit_count_m !== 7'(mcnt)) cnt_err++;
   endtask

   always begin
      @(negedge clk);
      #4;
      if (areset_n && dout_valid && dout_ready) begin
         if (q.size() == 0) chk("unexpected_word", dout, ~dout);
         else begin
            logic [W-1:0] e;
            e = q.pop_front();
            chk("sb_word_lsb", dout, e);
            chk("sb_word_msb", dout_m, rev(e));
            chk("sb_valid_msb", W'(dout_valid_m), W'(1));
            npop++;
         end
      end
   end

   initial begin
      int bad, n0;
      repeat (2) @(negedge clk);
      chk("rst_dout", dout, '0);
      chk("rst_valid", W'(dout_valid), '0);
      chk("rst_count", W'(bit_count), '0);
      chk("rst_in_ready", W'(in_ready), W'(1));
      areset_n = 1'b1;
      @(negedge clk);
      // bit order
      cyc(1, 1, 1, 0);
      for (int i = 1; i < W; i++) cyc(1, 0, 1, 0);
      chk("order_valid", W'(dout_valid), W'(1));
      chk("order_lsb", dout, one);
      chk("order_msb", dout_m, top);
      cyc(0, 0, 1, 0);
      chk("order_pulse", W'(dout_valid), '0);
      // backpressure
      bad = 0;
      for (int i = 0; i < 2 * W - 1; i++) begin
         cyc(1, i < W ? ~i[0] : i[0], 0, 0);
         if (in_ready !== (i < 2 * W - 2)) bad++;
      end
      chk("bp_in_ready_track", W'(bad), '0);
      chk("bp_count", W'(bit_count), W'(99));
      chk("bp_dout_a", dout, wa);
      cyc(1, 1, 0, 0);
      chk("bp_stall_count", W'(bit_count), W'(99));
      chk("bp_stall_dout", dout, wa);
      cyc(1, 1, 1, 0);
      chk("bp_dout_b", dout, wb);
      chk("bp_valid_b", W'(dout_valid), W'(1));
      cyc(0, 0, 1, 0);
      // back-to-back
      n0 = npop;
      bad = 0;
      for (int i = 0; i < 10 * W; i++) begin
         cyc(1, 1'($urandom), 1, 0);
         if (in_ready !== 1'b1) bad++;
      end
      cyc(0, 0, 1, 0);
      chk("b2b_in_ready", W'(bad), '0);
      chk("b2b_words", W'(npop - n0), W'(10));
      // flush with a pending word
      for (int i = 0; i < W; i++) cyc(1, ww[i], 0, 0);
      for (int i = 0; i < 37; i++) cyc(1, 1, 0, 0);
      chk("fl_count37", W'(bit_count), W'(37));
      cyc(1, 1, 0, 1);
      chk("fl_count0", W'(bit_count), '0);
      chk("fl_dout_w", dout, ww);
      chk("fl_valid_w", W'(dout_valid), W'(1));
      for (int i = 0; i < W; i++) cyc(1, 0, 1, 0);
      chk("fl_clean", dout, '0);
      chk("fl_clean_valid", W'(dout_valid), W'(1));
      cyc(0, 0, 1, 0);
      // gapped input
      n0 = npop;
      for (int i = 0; i < 700; i++) cyc($urandom_range(0, 9) < 3, 1'($urandom), 1, 0);
      for (int i = 0; i < 2 * W && mcnt != 0; i++) cyc(1, 1'($urandom), 1, 0);
      cyc(0, 0, 1, 0);
      chk("gap_words_seen", W'(npop - n0 > 0), W'(1));
      chk("gap_drained", W'(q.size()), '0);
      // asynchronous reset with a pending word and a partial word
      for (int i = 0; i < W + 50; i++) cyc(1, 1'($urandom), 0, 0);
      chk("pre_rst_count", W'(bit_count), W'(50));
      chk("pre_rst_valid", W'(dout_valid), W'(1));
      #2 areset_n = 1'b0;
      #1;
      chk("arst_dout", dout, '0);
      chk("arst_valid", W'(dout_valid), '0);
      chk("arst_count", W'(bit_count), '0);
      q.delete();
      mcnt = 0;
      mword = '0;
      @(negedge clk);
      areset_n = 1'b1;
      #1;
      chk("arst_in_ready", W'(in_ready), W'(1));
      @(negedge clk);
      chk("count_track", W'(cnt_err), '0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
